pixel_apb_master: RTL
=====================

# pixel_apb_master

Bus-master DMA engine that drains 32-bit packed pixel words from the camera pixel FIFO and writes them over an APB master port to a word-aligned destination region, one APB write per word. It sits between `fifo_pixel_data` (read side) and the fabric APB interconnect. It is the initiator counterpart to the imager's APB responder, so frames move to memory without per-word CPU reads.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum consecutive ACCESS cycles with `M_PREADY` low before the transfer is abandoned.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: pulse; begins a transfer when IDLE.
- `abort` in 1: pulse; ends the transfer at the next safe point.
- `base_addr` in 32: destination byte address; bits [1:0] are ignored and forced to 00.
- `word_count` in 16: number of words to move; 0 is legal.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of every transfer.
- `error` out 1: sticky; cleared by the next accepted `start` or by reset.
- `words_sent` out 16: words completed in the current or last transfer.
- `fifo_read_enable` out 1: one-cycle read strobe to the FIFO.
- `fifo_read_data` in 32: FIFO read data.
- `fifo_data_valid` in 1: asserted exactly one cycle after `fifo_read_enable`.
- `fifo_empty` in 1: FIFO empty flag.
- `M_PSEL`, `M_PENABLE`, `M_PWRITE` out 1 each: APB master controls.
- `M_PADDR` out 32, `M_PWDATA` out 32: APB address and write data.
- `M_PREADY`, `M_PSLVERR` in 1 each: APB slave responses.

## Operation
- Reset values:
  - State IDLE.
  - All outputs 0, including `error`, `words_sent`, `M_PADDR` and `M_PWDATA`.
- All outputs are registered.
- FSM states: IDLE, FETCH, WAIT_DATA, SETUP, ACCESS, DONE.
- IDLE:
  - `start` latches `base_addr & ~3` into the address register and `word_count` into the limit register.
  - It also clears `words_sent` and `error`.
  - Next state is DONE if `word_count`==0, else FETCH.
  - `start` in any other state is ignored.
- FETCH: if `!fifo_empty`, pulse `fifo_read_enable` for one cycle and go to WAIT_DATA; otherwise stay in FETCH indefinitely.
- WAIT_DATA:
  - On `fifo_data_valid`, capture `fifo_read_data` into `M_PWDATA` and go to SETUP.
  - `fifo_data_valid` arriving in any other state is ignored.
- SETUP: `M_PSEL`=1, `M_PENABLE`=0, `M_PWRITE`=1; go to ACCESS.
- ACCESS: `M_PSEL`=`M_PENABLE`=`M_PWRITE`=1; wait for `M_PREADY`.
- On `M_PREADY`:
  - `words_sent`+1 and address+4, wrapping modulo 2^32.
  - If `M_PSLVERR`: set `error` and go to DONE.
  - Else if `words_sent`+1 == limit, or abort is pending: go to DONE.
  - Else go to FETCH.
- Timeout:
  - If `M_PREADY` stays low for `TIMEOUT_CYCLES` consecutive ACCESS cycles, drop `M_PSEL`/`M_PENABLE`, set `error` and go to DONE.
  - The word is not counted.
- Abort:
  - In FETCH or WAIT_DATA: go to DONE next cycle with no error. A word already read and in flight is discarded.
  - In SETUP or ACCESS: latched as pending; the current APB transfer completes normally before going to DONE.
  - In IDLE or DONE: no effect.
- DONE: `done`=1 and `busy`=1; go to IDLE next cycle.
- `M_PADDR` and `M_PWDATA` are held stable from SETUP through ACCESS completion.
- `M_PWRITE` is 0 whenever `M_PSEL`=0.

## Timing
- Start to first `M_PSEL`: `start` at cycle t gives FETCH at t+1, read strobe at t+1, WAIT_DATA at t+2, data valid at t+2, SETUP at t+3. This is 3 cycles with a non-empty FIFO.
- Per-word throughput: 4 cycles minimum (FETCH, WAIT_DATA, SETUP, ACCESS with zero-wait `M_PREADY`).
- Each APB wait state adds 1 cycle.
- `done` is asserted one cycle after the final ACCESS completes.
- `word_count`=0: `done` at t+1, IDLE at t+2.
- Reset mid-transfer: all APB outputs drop at the next edge. The shared reset also clears the slave.

## Structure
- Shared package `imager_pkg` holds:
  - the FSM state enum `dma_state_t`;
  - the constant `APB_WORD_STRIDE`=4;
  - the width constant `DMA_COUNT_W`=16.
- No sub-module: the FSM, address/count registers and timeout counter form one module.
- Instantiation in the imager top replaces the CPU FIFO-read path for cam0.

## Test plan
- Basic transfer:
  - Stimulus: `base_addr`=0x2000_0003, `word_count`=3, FIFO preloaded with 0xA, 0xB, 0xC, zero-wait slave.
  - Required response: writes to 0x2000_0000, 0x2000_0004 and 0x2000_0008 with data A, B, C; `done` 13 cycles after `start`; `error`=0; `words_sent`=3.
- Empty FIFO stall:
  - Stimulus: `word_count`=2 with the FIFO empty for 20 cycles, then fill it.
  - Required response: FSM holds in FETCH with no `M_PSEL`; the two writes follow the fill.
- Slave errors:
  - Stimulus: `M_PSLVERR` on word 2 of 4.
  - Required response: `words_sent`=2, `error`=1, `done` pulses, no third write.
  - Stimulus: `M_PREADY` held low.
  - Required response: `M_PSEL` drops after 255 ACCESS cycles, `error`=1, `words_sent` unchanged.
- Abort:
  - Stimulus: abort during ACCESS with a 5-cycle wait state.
  - Required response: the transfer completes and is counted, then DONE.
  - Stimulus: abort in FETCH.
  - Required response: DONE next cycle, `error`=0.
- Edge cases:
  - Stimulus: `word_count`=0.
  - Required response: `done` at t+1 with no APB activity.
  - Stimulus: `base_addr`=0xFFFF_FFFC, 2 words.
  - Required response: second write to 0x0000_0000.
  - Stimulus: `start` while busy.
  - Required response: ignored.
  - Stimulus: reset in ACCESS.
  - Required response: all outputs 0 the next cycle.

Source files
------------

// File: rtl/imager_pkg.sv
// Types and constants shared by the imager DMA blocks: the DMA state encoding,
// the APB word stride, the word-counter width and an address alignment helper.
package imager_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_SETUP     = 3'd3,
        ST_ACCESS    = 3'd4,
        ST_DONE      = 3'd5
    } dma_state_t;

    localparam logic [31:0] APB_WORD_STRIDE = 32'd4;
    localparam int          DMA_COUNT_W     = 16;

    // Clear the byte-lane bits so every beat lands on a 32-bit word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/pixel_apb_master.sv
// Pixel DMA engine: pulls packed pixel words from the camera FIFO and writes
// each one to consecutive word addresses through an APB master port.
module pixel_apb_master
    import imager_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [31:0]            base_addr,
    input  logic [DMA_COUNT_W-1:0] word_count,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [DMA_COUNT_W-1:0] words_sent,
    output logic                   fifo_read_enable,
    input  logic [31:0]            fifo_read_data,
    input  logic                   fifo_data_valid,
    input  logic                   fifo_empty,
    output logic                   M_PSEL,
    output logic                   M_PENABLE,
    output logic                   M_PWRITE,
    output logic [31:0]            M_PADDR,
    output logic [31:0]            M_PWDATA,
    input  logic                   M_PREADY,
    input  logic                   M_PSLVERR
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    dma_state_t             r_state;
    dma_state_t             w_next;
    logic                   w_beat_done;
    logic                   w_timeout;
    logic                   w_last;
    logic [TW-1:0]          r_wait_cnt;
    logic [DMA_COUNT_W-1:0] r_limit;
    logic [DMA_COUNT_W-1:0] r_words_sent;
    logic                   r_abort_pend;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_error;
    logic                   r_rd_en;
    logic                   r_psel;
    logic                   r_penable;
    logic                   r_pwrite;
    logic [31:0]            r_paddr;
    logic [31:0]            r_pwdata;

    // Next-state decode; FETCH leaves only once the registered read strobe has fired.
    always_comb begin
        w_next      = r_state;
        w_beat_done = 1'b0;
        w_timeout   = 1'b0;
        w_last      = ((r_words_sent + 16'd1) == r_limit);
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (word_count == 16'd0) ? ST_DONE : ST_FETCH;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    w_next = ST_DONE;
                end else if (r_rd_en) begin
                    w_next = ST_WAIT_DATA;
                end else begin
                    w_next = ST_FETCH;
                end
            end
            ST_WAIT_DATA: begin
                if (abort) begin
                    w_next = ST_DONE;
                end else if (fifo_data_valid) begin
                    w_next = ST_SETUP;
                end else begin
                    w_next = ST_WAIT_DATA;
                end
            end
            ST_SETUP: begin
                w_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (M_PREADY) begin
                    w_beat_done = 1'b1;
                    if (M_PSLVERR || w_last || r_abort_pend || abort) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next = ST_FETCH;
                    end
                end else if (r_wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout = 1'b1;
                    w_next    = ST_DONE;
                end else begin
                    w_next = ST_ACCESS;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Registered outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_en   <= 1'b0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
        end else begin
            r_busy    <= (w_next != ST_IDLE);
            r_done    <= (w_next == ST_DONE);
            // fifo_empty one cycle early is safe: only this engine drains the FIFO.
            r_rd_en   <= (w_next == ST_FETCH) && !fifo_empty;
            r_psel    <= (w_next == ST_SETUP) || (w_next == ST_ACCESS);
            r_penable <= (w_next == ST_ACCESS);
            r_pwrite  <= (w_next == ST_SETUP) || (w_next == ST_ACCESS);
        end
    end

    // Address, data, count and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_paddr      <= 32'd0;
            r_pwdata     <= 32'd0;
            r_limit      <= 16'd0;
            r_words_sent <= 16'd0;
            r_error      <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_paddr      <= word_align(base_addr);
                r_limit      <= word_count;
                r_words_sent <= 16'd0;
                r_error      <= 1'b0;
            end
            if ((r_state == ST_WAIT_DATA) && fifo_data_valid && !abort) begin
                r_pwdata <= fifo_read_data;
            end
            if (w_beat_done) begin
                r_words_sent <= r_words_sent + 16'd1;
                r_paddr      <= r_paddr + APB_WORD_STRIDE;
                if (M_PSLVERR) begin
                    r_error <= 1'b1;
                end
            end
            if (w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end

    // Abort during an APB beat waits for the beat; the wait counter tracks stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_abort_pend <= 1'b0;
            r_wait_cnt   <= '0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_abort_pend <= 1'b0;
            end else if (abort && ((r_state == ST_SETUP) || (r_state == ST_ACCESS))) begin
                r_abort_pend <= 1'b1;
            end
            if ((r_state == ST_ACCESS) && !M_PREADY) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    assign busy             = r_busy;
    assign done             = r_done;
    assign error            = r_error;
    assign words_sent       = r_words_sent;
    assign fifo_read_enable = r_rd_en;
    assign M_PSEL           = r_psel;
    assign M_PENABLE        = r_penable;
    assign M_PWRITE         = r_pwrite;
    assign M_PADDR          = r_paddr;
    assign M_PWDATA         = r_pwdata;

endmodule
